decode_stage: RTL and testbench
===============================

# decode_stage

RV64IM instruction decode stage sitting directly downstream of instruction fetch, which is the cache instruction port plus PC logic. Accepts one fetched `(pc, instr)` pair per cycle over a valid/ready handshake. Produces fully decoded fields, a sign-extended immediate and control flags in a single registered pipeline slot for the register-read/execute stage. Supports flush on redirect and counts decoded instructions.

## Interface
- `ADDR_WIDTH`, default 64: PC width.
- `XLEN`, default 64: immediate/data width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard the held slot and any same-cycle input.
- `in_valid` in 1: fetch has an instruction.
- `in_ready` out 1: the stage accepts the instruction this cycle.
- `in_pc` in ADDR_WIDTH: PC of the instruction.
- `in_instr` in 32: raw instruction word.
- `out_valid` out 1: the decoded slot is valid.
- `out_ready` in 1: the downstream stage consumes the slot.
- `out_pc` out ADDR_WIDTH; `out_instr` out 32: passthrough.
- `out_rd`, `out_rs1`, `out_rs2` out 5: register indices. Each is 0 when unused by the format.
- `out_imm` out XLEN: sign-extended immediate (I/S/B/U/J). 0 for R-type.
- `out_opclass` out 4: LUI=0, AUIPC=1, JAL=2, JALR=3, BRANCH=4, LOAD=5, STORE=6, OP_IMM=7, OP=8, OP_IMM_32=9, OP_32=10, SYSTEM=11, FENCE=12, ILLEGAL=15.
- `out_funct3` out 3; `out_funct7` out 7: raw fields.
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_branch`, `out_jump`, `out_alu_src_imm`, `out_is_word`, `out_is_muldiv`, `out_illegal`, `out_ecall` out 1 each: control flags.
- `out_mem_size` out 2: 0=B, 1=H, 2=W, 3=D; taken from funct3[1:0].
- `out_mem_unsigned` out 1: funct3[2] for loads.
- `decoded_count` out 64: number of output handshakes since reset.

## Operation
- **Slot.** Single pipeline register.
  - `in_ready = !out_valid || out_ready`, computed combinationally and independent of `in_valid`.
  - Accept when `in_valid && in_ready && !flush`. All out_* fields load next edge and `out_valid` goes to 1.
  - On `out_valid && out_ready` with no accept, `out_valid` goes to 0.
  - Simultaneous consume and accept keeps `out_valid` at 1 with the new contents.
- **Flush.** `out_valid` goes to 0 next edge. Same-cycle input is dropped, not accepted. `decoded_count` still counts a same-cycle output handshake.
- **Immediates.**
  - I: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All are sign-extended from instr[31] to XLEN. U-type is also sign-extended above bit 31.
- **Register use.**
  - STORE and BRANCH force `rd=0`.
  - LUI, AUIPC and JAL force `rs1=0`.
  - Only OP, OP_32, STORE and BRANCH carry `rs2`.
- **reg_write.** 1 for LUI, AUIPC, JAL, JALR, LOAD, OP*, OP_IMM*, and only when `rd != 0`.
- **Other flags.**
  - `alu_src_imm`: all non-R, non-BRANCH classes.
  - `is_word`: OP_32 and OP_IMM_32.
  - `is_muldiv`: OP or OP_32 with funct7=0000001.
  - `ecall`: SYSTEM with instr == 0x00000073.
- **Illegal.** Any of the following sets `out_illegal=1`, `opclass=15`, and clears `reg_write`, `mem_read` and `mem_write`:
  - instr[1:0] != 2'b11, or instr == 0.
  - Unknown opcode.
  - BRANCH funct3 010/011.
  - LOAD funct3 111.
  - STORE funct3[2]=1.
  - OP funct7 not in {0000000, 0100000 (funct3 000/101 only), 0000001}.
  - OP_32 funct7 not in {0000000, 0100000 (funct3 000/101 only), 0000001 (funct3 000/100/101/110/111)}.
  - OP_IMM shift with instr[31:26] not in {000000, 010000 for funct3=101}.
  - OP_IMM_32 funct3 not in {000, 001, 101}.
  - JALR funct3 != 0.
- **Counter.** `decoded_count` is a 64-bit counter that increments on `out_valid && out_ready` and wraps at 2^64-1 → 0.

## Timing
- Reset: `out_valid=0`, all out_* fields 0, `decoded_count=0`. `in_ready` is 1 in the cycle after reset deasserts.
- Latency 1 cycle from input accept to `out_valid`. Throughput 1 instruction/cycle while `out_ready=1`.
- Outputs hold stable while `out_valid && !out_ready`.
- Reset overrides flush and handshakes. Reset mid-stall empties the slot.
- No combinational path from `in_*` to `out_*`. `out_ready` reaches `in_ready` combinationally only.

## Test plan
- Reset, then `in_valid=1` with `pc=0x1000`, `instr=0x00500093` (addi x1,x0,5) → the next cycle shows `out_valid=1`, `rd=1`, `rs1=0`, `imm=5`, `opclass=7`, `reg_write=1`; `decoded_count=1` after the handshake.
- `instr=0x0020B423` (sd x2,8(x1)) → `opclass=6`, `rd=0`, `rs1=1`, `rs2=2`, `imm=8`, `mem_write=1`, `mem_size=3`, `reg_write=0`. `instr=0xFE000EE3` (beq x0,x0,-4) → `imm=0xFFFFFFFFFFFFFFFC`, `branch=1`.
- `instr=0x123452B7` (lui x5,0x12345) → `imm=0x0000000012345000`, `opclass=0`. `instr=0x800002B7` → `imm=0xFFFFFFFF80000000`.
- Hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0`, outputs frozen, the second instruction appears only after `out_ready` rises, and none are lost or duplicated.
- Assert `flush` with `out_valid=1` and `in_valid=1` → the next cycle has `out_valid=0` and the flushed input is never emitted.
- `instr=0x00000000`, `0x02001033` (funct7=0000001 funct3=001 on OP: legal mulh) and `0x0000700B` → the first and third give `illegal=1`, `opclass=15`, `reg_write=0`; the second gives `is_muldiv=1`, `illegal=0`.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake plus the decoded slot handed to register read.
// master = the side driving fetch data and out_ready, slave = the decode stage.
interface decode_stage_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int XLEN       = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic [31:0]           in_instr;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [31:0]           out_instr;
    logic [4:0]            out_rd, out_rs1, out_rs2;
    logic [XLEN-1:0]       out_imm;
    logic [3:0]            out_opclass;
    logic [2:0]            out_funct3;
    logic [6:0]            out_funct7;
    logic                  out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump;
    logic                  out_alu_src_imm, out_is_word, out_is_muldiv, out_illegal, out_ecall;
    logic [1:0]            out_mem_size;
    logic                  out_mem_unsigned;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_rd, out_rs1, out_rs2, out_imm,
               out_opclass, out_funct3, out_funct7, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_jump, out_alu_src_imm, out_is_word,
               out_is_muldiv, out_illegal, out_ecall, out_mem_size, out_mem_unsigned
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_rd, out_rs1, out_rs2, out_imm,
               out_opclass, out_funct3, out_funct7, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_jump, out_alu_src_imm, out_is_word,
               out_is_muldiv, out_illegal, out_ecall, out_mem_size, out_mem_unsigned
    );
endinterface

// File: rtl/decode_stage.sv
// Single-slot RV64IM decode stage: decodes the fetched word combinationally and
// registers the full result on accept; counts output handshakes.
module decode_stage #(
    parameter int ADDR_WIDTH = 64,
    parameter int XLEN       = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    output logic [63:0]   decoded_count,
    decode_stage_if.slave bus
);
    typedef enum logic [3:0] {
        C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3, C_BRANCH = 4'd4,
        C_LOAD = 4'd5, C_STORE = 4'd6, C_OP_IMM = 4'd7, C_OP = 4'd8, C_OP_IMM_32 = 4'd9,
        C_OP_32 = 4'd10, C_SYSTEM = 4'd11, C_FENCE = 4'd12, C_ILLEGAL = 4'd15
    } opclass_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [31:0]           instr;
        logic [4:0]            rd, rs1, rs2;
        logic [XLEN-1:0]       imm;
        logic [3:0]            opclass;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic                  reg_write, mem_read, mem_write, branch, jump;
        logic                  alu_src_imm, is_word, is_muldiv, illegal, ecall;
        logic [1:0]            mem_size;
        logic                  mem_unsigned;
    } slot_t;

    logic [31:0] ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    opclass_e    cls;
    logic        bad;
    logic        writes_rd;
    slot_t       dec, slot;
    logic        valid, ready, accept;

    assign ins = bus.in_instr;
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    always_comb begin
        case (ins[6:0])
            7'b0110111: cls = C_LUI;
            7'b0010111: cls = C_AUIPC;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            7'b1100011: cls = C_BRANCH;
            7'b0000011: cls = C_LOAD;
            7'b0100011: cls = C_STORE;
            7'b0010011: cls = C_OP_IMM;
            7'b0110011: cls = C_OP;
            7'b0011011: cls = C_OP_IMM_32;
            7'b0111011: cls = C_OP_32;
            7'b1110011: cls = C_SYSTEM;
            7'b0001111: cls = C_FENCE;
            default:    cls = C_ILLEGAL;
        endcase
    end

    // Per-class encoding holes; a word of zero already fails the [1:0] test.
    always_comb begin
        bad = (ins[1:0] != 2'b11) || (cls == C_ILLEGAL);
        case (cls)
            C_BRANCH:    bad = bad || (f3 inside {3'b010, 3'b011});
            C_LOAD:      bad = bad || (f3 == 3'b111);
            C_STORE:     bad = bad || f3[2];
            C_JALR:      bad = bad || (f3 != 3'b000);
            C_OP:        bad = bad || !(f7 == 7'b0000000 || f7 == 7'b0000001 ||
                                        (f7 == 7'b0100000 && f3 inside {3'b000, 3'b101}));
            C_OP_32:     bad = bad || !(f7 == 7'b0000000 ||
                                        (f7 == 7'b0100000 && f3 inside {3'b000, 3'b101}) ||
                                        (f7 == 7'b0000001 && f3 inside {3'b000, 3'b100, 3'b101, 3'b110, 3'b111}));
            C_OP_IMM:    if (f3 inside {3'b001, 3'b101})
                             bad = bad || !(ins[31:26] == 6'b000000 ||
                                            (ins[31:26] == 6'b010000 && f3 == 3'b101));
            C_OP_IMM_32: bad = bad || !(f3 inside {3'b000, 3'b001, 3'b101});
            default:     bad = bad;
        endcase
    end

    assign writes_rd = cls inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD,
                                   C_OP, C_OP_32, C_OP_IMM, C_OP_IMM_32};

    always_comb begin
        dec        = '0;
        dec.pc     = bus.in_pc;
        dec.instr  = ins;
        dec.funct3 = f3;
        dec.funct7 = f7;
        dec.rd     = (cls inside {C_STORE, C_BRANCH}) ? 5'd0 : ins[11:7];
        dec.rs1    = (cls inside {C_LUI, C_AUIPC, C_JAL}) ? 5'd0 : ins[19:15];
        dec.rs2    = (cls inside {C_OP, C_OP_32, C_STORE, C_BRANCH}) ? ins[24:20] : 5'd0;
        case (cls)
            C_LUI, C_AUIPC: dec.imm = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
            C_JAL:    dec.imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            C_BRANCH: dec.imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            C_STORE:  dec.imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            C_OP, C_OP_32, C_ILLEGAL: dec.imm = '0;
            default:  dec.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
        endcase
        dec.opclass      = bad ? C_ILLEGAL : cls;
        dec.illegal      = bad;
        dec.reg_write    = writes_rd && (ins[11:7] != 5'd0) && !bad;
        dec.mem_read     = (cls == C_LOAD) && !bad;
        dec.mem_write    = (cls == C_STORE) && !bad;
        dec.branch       = (cls == C_BRANCH);
        dec.jump         = cls inside {C_JAL, C_JALR};
        dec.alu_src_imm  = !(cls inside {C_OP, C_OP_32, C_BRANCH, C_ILLEGAL});
        dec.is_word      = cls inside {C_OP_32, C_OP_IMM_32};
        dec.is_muldiv    = (cls inside {C_OP, C_OP_32}) && (f7 == 7'b0000001);
        dec.ecall        = (cls == C_SYSTEM) && (ins == 32'h0000_0073);
        dec.mem_size     = f3[1:0];
        dec.mem_unsigned = (cls == C_LOAD) && f3[2];
    end

    // Ready depends only on slot state and out_ready, never on in_valid.
    assign ready  = !valid || bus.out_ready;
    assign accept = bus.in_valid && ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot          <= '0;
            valid         <= 1'b0;
            decoded_count <= 64'd0;
        end else begin
            if (valid && bus.out_ready)
                decoded_count <= decoded_count + 64'd1;
            if (accept) begin
                slot  <= dec;
                valid <= 1'b1;
            end else if (flush || bus.out_ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready         = ready;
    assign bus.out_valid        = valid;
    assign bus.out_pc           = slot.pc;
    assign bus.out_instr        = slot.instr;
    assign bus.out_rd           = slot.rd;
    assign bus.out_rs1          = slot.rs1;
    assign bus.out_rs2          = slot.rs2;
    assign bus.out_imm          = slot.imm;
    assign bus.out_opclass      = slot.opclass;
    assign bus.out_funct3       = slot.funct3;
    assign bus.out_funct7       = slot.funct7;
    assign bus.out_reg_write    = slot.reg_write;
    assign bus.out_mem_read     = slot.mem_read;
    assign bus.out_mem_write    = slot.mem_write;
    assign bus.out_branch       = slot.branch;
    assign bus.out_jump         = slot.jump;
    assign bus.out_alu_src_imm  = slot.alu_src_imm;
    assign bus.out_is_word      = slot.is_word;
    assign bus.out_is_muldiv    = slot.is_muldiv;
    assign bus.out_illegal      = slot.illegal;
    assign bus.out_ecall        = slot.ecall;
    assign bus.out_mem_size     = slot.mem_size;
    assign bus.out_mem_unsigned = slot.mem_unsigned;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode table, stall/flush/reset sequences,
// then a random stream against a queue-based reference model.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [63:0] decoded_count;

    decode_stage_if #(.ADDR_WIDTH(64), .XLEN(64)) bus ();

    decode_stage #(.ADDR_WIDTH(64), .XLEN(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .decoded_count (decoded_count),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic [3:0]  opclass;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw, mr, mw, br, jmp, asi, word, md, ill, ecall;
        logic [1:0]  msize;
        logic        mu;
    } exp_t;

    // flags = {reg_write, mem_read, mem_write, branch, jump, is_muldiv, illegal, ecall}
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic [7:0]  fl;
        logic [1:0]  msz;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference decode written from the ISA rules, one opcode at a time.
    function automatic exp_t model(input logic [63:0] pc, input logic [31:0] w);
        exp_t e;
        logic signed [11:0] ii, ss;
        logic signed [12:0] bb;
        logic signed [31:0] uu;
        logic signed [20:0] jj;
        logic [2:0] f3;
        logic [6:0] f7;
        bit legal, wr;
        int cls;
        ii = w[31:20];
        ss = {w[31:25], w[11:7]};
        bb = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        uu = {w[31:12], 12'h000};
        jj = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.pc = pc; e.instr = w; e.f3 = f3; e.f7 = f7; e.msize = f3[1:0];
        e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = 5'd0;
        legal = 1; wr = 0; e.asi = 1;
        case (w[6:0])
            7'h37: begin cls = 0; e.imm = uu; e.rs1 = 0; wr = 1; end
            7'h17: begin cls = 1; e.imm = uu; e.rs1 = 0; wr = 1; end
            7'h6F: begin cls = 2; e.imm = jj; e.rs1 = 0; wr = 1; e.jmp = 1; end
            7'h67: begin cls = 3; e.imm = ii; wr = 1; e.jmp = 1; legal = (f3 == 0); end
            7'h63: begin cls = 4; e.imm = bb; e.rd = 0; e.rs2 = w[24:20]; e.br = 1; e.asi = 0;
                         legal = (f3 != 2 && f3 != 3); end
            7'h03: begin cls = 5; e.imm = ii; wr = 1; e.mr = 1; e.mu = f3[2]; legal = (f3 != 7); end
            7'h23: begin cls = 6; e.imm = ss; e.rd = 0; e.rs2 = w[24:20]; e.mw = 1; legal = (f3 < 4); end
            7'h13: begin cls = 7; e.imm = ii; wr = 1;
                         if (f3 == 1) legal = (w[31:26] == 0);
                         if (f3 == 5) legal = (w[31:26] == 0 || w[31:26] == 6'd16); end
            7'h33: begin cls = 8; e.rs2 = w[24:20]; wr = 1; e.asi = 0; e.md = (f7 == 1);
                         legal = (f7 == 0 || f7 == 1 || (f7 == 32 && (f3 == 0 || f3 == 5))); end
            7'h1B: begin cls = 9; e.imm = ii; wr = 1; e.word = 1; legal = (f3 == 0 || f3 == 1 || f3 == 5); end
            7'h3B: begin cls = 10; e.rs2 = w[24:20]; wr = 1; e.asi = 0; e.word = 1; e.md = (f7 == 1);
                         legal = (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)) ||
                                  (f7 == 1 && f3 != 1 && f3 != 2 && f3 != 3)); end
            7'h73: begin cls = 11; e.imm = ii; e.ecall = (w == 32'h73); end
            7'h0F: begin cls = 12; e.imm = ii; end
            default: begin cls = 15; legal = 0; e.asi = 0; end
        endcase
        e.opclass = 4'(cls);
        e.rw = wr && (e.rd != 0);
        if (!legal) begin
            e.ill = 1; e.opclass = 4'd15; e.rw = 0; e.mr = 0; e.mw = 0;
        end
        return e;
    endfunction

    // For illegal words only the fields with a defined meaning are compared.
    function automatic exp_t mask(input exp_t x, input logic ill);
        exp_t m;
        if (!ill) return x;
        m = '0;
        m.pc = x.pc; m.instr = x.instr; m.opclass = x.opclass;
        m.ill = x.ill; m.rw = x.rw; m.mr = x.mr; m.mw = x.mw;
        return m;
    endfunction

    function automatic exp_t dut_view();
        exp_t e;
        e.pc = bus.out_pc; e.instr = bus.out_instr;
        e.rd = bus.out_rd; e.rs1 = bus.out_rs1; e.rs2 = bus.out_rs2;
        e.imm = bus.out_imm; e.opclass = bus.out_opclass;
        e.f3 = bus.out_funct3; e.f7 = bus.out_funct7;
        e.rw = bus.out_reg_write; e.mr = bus.out_mem_read; e.mw = bus.out_mem_write;
        e.br = bus.out_branch; e.jmp = bus.out_jump; e.asi = bus.out_alu_src_imm;
        e.word = bus.out_is_word; e.md = bus.out_is_muldiv; e.ill = bus.out_illegal;
        e.ecall = bus.out_ecall; e.msize = bus.out_mem_size; e.mu = bus.out_mem_unsigned;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [13];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h73, 7'h0F};
        w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            w[6:0] = ops[$urandom_range(0, 12)];
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  gfl;
        exp_t        e;
        exp_t        q [$];
        logic [63:0] mcnt;
        logic        mv, acc;

        vt[0]  = '{32'h00500093, 4'd7,  5'd1,  5'd0,  5'd0,  64'd5,                  8'h80, 2'd0};
        vt[1]  = '{32'h0020B423, 4'd6,  5'd0,  5'd1,  5'd2,  64'd8,                  8'h20, 2'd3};
        vt[2]  = '{32'hFE000EE3, 4'd4,  5'd0,  5'd0,  5'd0,  64'hFFFFFFFFFFFFFFFC,   8'h10, 2'd0};
        vt[3]  = '{32'h123452B7, 4'd0,  5'd5,  5'd0,  5'd0,  64'h0000000012345000,   8'h80, 2'd0};
        vt[4]  = '{32'h800002B7, 4'd0,  5'd5,  5'd0,  5'd0,  64'hFFFFFFFF80000000,   8'h80, 2'd0};
        vt[5]  = '{32'h00000000, 4'd15, 5'd0,  5'd0,  5'd0,  64'd0,                  8'h02, 2'd0};
        vt[6]  = '{32'h02001033, 4'd8,  5'd0,  5'd0,  5'd0,  64'd0,                  8'h04, 2'd0};
        vt[7]  = '{32'h0000700B, 4'd15, 5'd0,  5'd0,  5'd0,  64'd0,                  8'h02, 2'd0};
        vt[8]  = '{32'h40B50533, 4'd8,  5'd10, 5'd10, 5'd11, 64'd0,                  8'h80, 2'd0};
        vt[9]  = '{32'h40B51533, 4'd15, 5'd0,  5'd0,  5'd0,  64'd0,                  8'h02, 2'd0};
        vt[10] = '{32'h000280E7, 4'd3,  5'd1,  5'd5,  5'd0,  64'd0,                  8'h88, 2'd0};
        vt[11] = '{32'h00000073, 4'd11, 5'd0,  5'd0,  5'd0,  64'd0,                  8'h01, 2'd0};
        vt[12] = '{32'h008000EF, 4'd2,  5'd1,  5'd0,  5'd0,  64'd8,                  8'h88, 2'd0};
        vt[13] = '{32'h01016183, 4'd5,  5'd3,  5'd2,  5'd0,  64'd16,                 8'hC0, 2'd2};
        vt[14] = '{32'h40109093, 4'd15, 5'd0,  5'd0,  5'd0,  64'd0,                  8'h02, 2'd0};
        vt[15] = '{32'h4210D093, 4'd7,  5'd1,  5'd1,  5'd0,  64'h421,                8'h80, 2'd0};
        vt[16] = '{32'h00002063, 4'd15, 5'd0,  5'd0,  5'd0,  64'd0,                  8'h02, 2'd0};
        vt[17] = '{32'h0200103B, 4'd15, 5'd0,  5'd0,  5'd0,  64'd0,                  8'h02, 2'd0};

        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {bus.out_valid, decoded_count, bus.out_instr, bus.out_imm, bus.out_opclass},
              {1'b0, 64'd0, 32'd0, 64'd0, 4'd0});
        reset = 1'b0;
        #1;
        check("ready_after_reset", bus.in_ready, 1'b1);

        // Directed decode table, one instruction at a time with out_ready high.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_instr = vt[i].instr;
            bus.in_pc = 64'h1000 + 64'(4 * i); bus.out_ready = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            gfl = {bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_branch,
                   bus.out_jump, bus.out_is_muldiv, bus.out_illegal, bus.out_ecall};
            if (vt[i].fl[1])
                check($sformatf("vec%0d_illegal", i),
                      {bus.out_valid, bus.out_opclass, gfl[7:5], gfl[1]},
                      {1'b1, vt[i].opc, vt[i].fl[7:5], vt[i].fl[1]});
            else
                check($sformatf("vec%0d", i),
                      {bus.out_valid, bus.out_pc, bus.out_opclass, bus.out_rd, bus.out_rs1, bus.out_rs2,
                       bus.out_imm, gfl, (vt[i].fl[6] | vt[i].fl[5]) ? bus.out_mem_size : 2'd0},
                      {1'b1, 64'h1000 + 64'(4 * i), vt[i].opc, vt[i].rd, vt[i].rs1, vt[i].rs2,
                       vt[i].imm, vt[i].fl, (vt[i].fl[6] | vt[i].fl[5]) ? vt[i].msz : 2'd0});
            check($sformatf("count%0d", i), decoded_count, 64'(i));
        end

        // Stall: first instruction held for 3 cycles, second waits behind it.
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h00500093; bus.in_pc = 64'h2000;
        @(negedge clk);
        bus.in_instr = 32'h0020B423; bus.in_pc = 64'h2004;
        repeat (3) begin
            check("stall_hold", {bus.out_valid, bus.in_ready, bus.out_instr, bus.out_pc},
                  {1'b1, 1'b0, 32'h00500093, 64'h2000});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check("ready_from_out_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("stall_second", {bus.out_valid, bus.out_instr, bus.out_pc}, {1'b1, 32'h0020B423, 64'h2004});
        @(negedge clk);
        check("stall_drain", {bus.out_valid, decoded_count}, {1'b0, 64'(NV + 2)});

        // Flush with a held slot and a same-cycle input: both are discarded.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h40B50533; bus.in_pc = 64'h3000;
        @(negedge clk);
        check("flush_pre", {bus.out_valid, bus.out_instr}, {1'b1, 32'h40B50533});
        flush = 1'b1; bus.in_instr = 32'h000280E7; bus.in_pc = 64'h3004;
        @(negedge clk);
        check("flush_empty", bus.out_valid, 1'b0);
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        check("flush_dropped", {bus.out_valid, decoded_count}, {1'b0, 64'(NV + 2)});

        // Reset while stalled empties the slot and clears the counter.
        bus.in_valid = 1'b1; bus.in_instr = 32'h123452B7; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("reset_mid_stall", {bus.out_valid, decoded_count, bus.out_instr}, {1'b0, 64'd0, 32'd0});
        reset = 1'b0;
        #1;
        check("ready_after_reset2", bus.in_ready, 1'b1);

        // Random stream vs queue model.
        mcnt = 64'd0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_instr  = rand_instr();
            bus.in_pc     = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            #1;
            mv = (q.size() != 0);
            check("rnd_ctl", {bus.out_valid, bus.in_ready, decoded_count}, {mv, !mv || bus.out_ready, mcnt});
            acc = bus.in_valid && (!mv || bus.out_ready) && !flush;
            if (mv && bus.out_ready) begin
                e = q.pop_front();
                check("rnd_out", mask(dut_view(), e.ill), mask(e, e.ill));
                mcnt++;
            end
            if (flush) q.delete();
            else if (acc) q.push_back(model(bus.in_pc, bus.in_instr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
